// File: rtl/ntt_intt_obi_responder.sv
// OBI responder for the NTT/INTT window: 128-word coefficient buffer plus CTRL/STATUS, single-cycle gnt->rvalid.
// Buffer accesses are stalled (gnt=0) while the core owns the buffer; CSR accesses are always granted.
module ntt_intt_obi_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          NUM_WORDS = 128
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        slave_req_i,
   input  logic [31:0] slave_addr_i,
   input  logic        slave_we_i,
   input  logic [3:0]  slave_be_i,
   input  logic [31:0] slave_wdata_i,
   output logic        slave_gnt_o,
   output logic        slave_rvalid_o,
   output logic [31:0] slave_rdata_o,
   output logic        core_start_o,
   output logic        core_mode_o,
   input  logic        core_done_i,
   input  logic        core_mem_req_i,
   input  logic        core_mem_we_i,
   input  logic [6:0]  core_mem_addr_i,
   input  logic [31:0] core_mem_wdata_i,
   output logic [31:0] core_mem_rdata_o,
   output logic        irq_o
);
   localparam int AW = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [31:0] mem [NUM_WORDS];
   logic        ctrl_mode;
   logic        ctrl_irq_en;
   logic        done;

   logic [9:0]    offs;
   logic [AW-1:0] idx;
   logic          is_buf;
   logic          is_ctrl;
   logic          is_stat;
   logic          wr;
   logic          ctrl_wr;
   logic          start_wr;
   logic          w1c;
   logic [31:0]   bemask;
   logic [31:0]   rd_val;

   assign offs     = 10'(slave_addr_i - BASE_ADDR);
   assign is_buf   = offs < 10'(NUM_WORDS * 4);
   assign is_ctrl  = offs == 10'h200;
   assign is_stat  = offs == 10'h204;
   assign idx      = offs[AW+1:2];

   assign slave_gnt_o = slave_req_i && !(is_buf && state == BUSY);

   assign wr       = slave_gnt_o && slave_we_i;
   assign ctrl_wr  = wr && is_ctrl && slave_be_i[0];
   assign start_wr = ctrl_wr && slave_wdata_i[0];
   assign w1c      = wr && is_stat && slave_be_i[0] && slave_wdata_i[1];
   assign bemask   = {{8{slave_be_i[3]}}, {8{slave_be_i[2]}},
                      {8{slave_be_i[1]}}, {8{slave_be_i[0]}}};

   assign core_mode_o = ctrl_mode;
   assign irq_o       = done & ctrl_irq_en;

   always_comb begin
      rd_val = '0;
      if (is_buf)
         rd_val = mem[idx];
      else if (is_ctrl)
         rd_val = {29'd0, ctrl_irq_en, ctrl_mode, 1'b0};
      else if (is_stat)
         rd_val = {30'd0, done, state == BUSY};
   end

   // Buffer has a single write port: the core owns it in BUSY, the bus otherwise.
   always_ff @(posedge clk_i) begin
      if (state == BUSY) begin
         if (core_mem_req_i && core_mem_we_i)
            mem[core_mem_addr_i] <= core_mem_wdata_i;
      end else if (wr && is_buf) begin
         mem[idx] <= (mem[idx] & ~bemask) | (slave_wdata_i & bemask);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slave_rvalid_o   <= 1'b0;
         slave_rdata_o    <= '0;
         core_mem_rdata_o <= '0;
      end else begin
         slave_rvalid_o   <= slave_gnt_o;
         slave_rdata_o    <= (slave_gnt_o && !slave_we_i) ? rd_val : '0;
         core_mem_rdata_o <= (state == BUSY && core_mem_req_i && !core_mem_we_i)
                             ? mem[core_mem_addr_i] : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         ctrl_mode    <= 1'b0;
         ctrl_irq_en  <= 1'b0;
         done         <= 1'b0;
         core_start_o <= 1'b0;
      end else begin
         core_start_o <= 1'b0;
         if (ctrl_wr) begin
            ctrl_irq_en <= slave_wdata_i[2];
            // mode must stay stable while the core is running
            if (state != BUSY)
               ctrl_mode <= slave_wdata_i[1];
         end
         case (state)
            IDLE: begin
               if (start_wr) begin
                  state        <= BUSY;
                  core_start_o <= 1'b1;
               end
            end
            BUSY: begin
               if (core_done_i) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (start_wr) begin
                  done         <= 1'b0;
                  state        <= BUSY;
                  core_start_o <= 1'b1;
               end else if (w1c) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ntt_intt_obi_responder.sv
// Directed + randomized bench for ntt_intt_obi_responder against a behavioural buffer/CSR model.
module tb_ntt_intt_obi_responder;
   localparam logic [31:0] BASE = 32'h2000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        core_start;
   logic        core_mode;
   logic        core_done = 1'b0;
   logic        cm_req = 1'b0;
   logic        cm_we = 1'b0;
   logic [6:0]  cm_addr = '0;
   logic [31:0] cm_wdata = '0;
   logic [31:0] cm_rdata;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_buf [128];
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_mode = 1'b0;
   logic        m_irqen = 1'b0;

   ntt_intt_obi_responder #(.BASE_ADDR(BASE), .NUM_WORDS(128)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .slave_req_i(req), .slave_addr_i(addr), .slave_we_i(we), .slave_be_i(be),
      .slave_wdata_i(wdata), .slave_gnt_o(gnt), .slave_rvalid_o(rvalid),
      .slave_rdata_o(rdata), .core_start_o(core_start), .core_mode_o(core_mode),
      .core_done_i(core_done), .core_mem_req_i(cm_req), .core_mem_we_i(cm_we),
      .core_mem_addr_i(cm_addr), .core_mem_wdata_i(cm_wdata),
      .core_mem_rdata_o(cm_rdata), .irq_o(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [9:0] off);
      if (off < 10'd512) return m_buf[off[8:2]];
      if (off == 10'h200) return {29'd0, m_irqen, m_mode, 1'b0};
      if (off == 10'h204) return {30'd0, m_done, m_busy};
      return 32'd0;
   endfunction

   task automatic model_write(input logic [9:0] off, input logic [3:0] b, input logic [31:0] d);
      if (off < 10'd512) begin
         for (int k = 0; k < 4; k++)
            if (b[k]) m_buf[off[8:2]][8*k +: 8] = d[8*k +: 8];
      end else if (off == 10'h200 && b[0]) begin
         m_irqen = d[2];
         if (!m_busy) begin
            m_mode = d[1];
            if (d[0]) begin m_busy = 1'b1; m_done = 1'b0; end
         end
      end else if (off == 10'h204 && b[0] && d[1] && !m_busy) begin
         m_done = 1'b0;
      end
   endtask

   // One bus transaction; returns at the response sample point with req dropped.
   task automatic bus(input logic w, input logic [9:0] off, input logic [3:0] b, input logic [31:0] d);
      logic [31:0] exp;
      int n;
      @(negedge clk);
      req = 1'b1; we = w; addr = BASE + {22'd0, off}; be = b; wdata = d;
      #1;
      n = 0;
      while (!gnt && n < 40) begin @(negedge clk); #1; n++; end
      if (!gnt) begin
         chk("gnt_timeout", {31'd0, gnt}, 32'd1);
         req = 1'b0;
         return;
      end
      exp = w ? 32'd0 : exp_read(off);
      if (w) model_write(off, b, d);
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("rvalid", {31'd0, rvalid}, 32'd1);
      chk(w ? "wr_ack_rdata" : "rd_rdata", rdata, exp);
   endtask

   task automatic core_op(input logic w, input logic [6:0] a, input logic [31:0] d, output logic [31:0] r);
      @(negedge clk);
      cm_req = 1'b1; cm_we = w; cm_addr = a; cm_wdata = d;
      @(negedge clk);
      cm_req = 1'b0; cm_we = 1'b0;
      #1;
      r = cm_rdata;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] v;
      logic [9:0]  off;

      // reset state
      #1;
      chk("rst_gnt", {31'd0, gnt}, 0);
      chk("rst_rvalid", {31'd0, rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_start", {31'd0, core_start}, 0);
      chk("rst_mode", {31'd0, core_mode}, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      chk("rst_cm_rdata", cm_rdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 128; i++) bus(1'b1, 10'(i * 4), 4'hF, $urandom);

      // directed buffer/byte-enable/unmapped checks
      bus(1'b1, 10'h004, 4'hF, 32'h0ABC_0123);
      bus(1'b0, 10'h004, 4'hF, 0);
      bus(1'b1, 10'h004, 4'b0011, 32'hFFFF_FFFF);
      bus(1'b0, 10'h004, 4'hF, 0);
      chk("be_merge_model", m_buf[1], 32'h0ABC_FFFF);
      bus(1'b1, 10'h3F0, 4'hF, 32'hDEAD_BEEF);
      bus(1'b0, 10'h3F0, 4'hF, 0);
      bus(1'b0, 10'h1FC, 4'hF, 0);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) off = 10'(10'h208 + 4 * $urandom_range(0, 125));
         else off = 10'(4 * $urandom_range(0, 127));
         bus(1'($urandom), off, 4'($urandom), $urandom);
      end

      // CTRL write without be[0] must not start
      bus(1'b1, 10'h200, 4'b1110, 32'h7);
      chk("no_start_be", {31'd0, core_start}, 0);
      bus(1'b0, 10'h204, 4'hF, 0);

      // start NTT... in INTT mode
      bus(1'b1, 10'h200, 4'hF, 32'h3);
      chk("start_pulse", {31'd0, core_start}, 1);
      chk("mode_latched", {31'd0, core_mode}, 1);
      @(negedge clk); #1;
      chk("start_one_cycle", {31'd0, core_start}, 0);
      bus(1'b0, 10'h204, 4'hF, 0);
      bus(1'b1, 10'h200, 4'hF, 32'h0);
      chk("mode_stable_busy", {31'd0, core_mode}, 1);
      bus(1'b0, 10'h200, 4'hF, 0);

      v = $urandom;
      core_op(1'b1, 7'd5, v, r);
      m_buf[5] = v;
      core_op(1'b0, 7'd5, 0, r);
      chk("core_rd_own", r, v);
      core_op(1'b0, 7'd1, 0, r);
      chk("core_rd_bus", r, m_buf[1]);

      // bus buffer read stalls until done
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = BASE; be = 4'hF;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("busy_stall_gnt", {31'd0, gnt}, 0);
         @(negedge clk); #1;
      end
      core_done = 1'b1;
      chk("stall_on_done_cycle", {31'd0, gnt}, 0);
      @(negedge clk);
      core_done = 1'b0;
      m_busy = 1'b0; m_done = 1'b1;
      #1;
      chk("gnt_after_done", {31'd0, gnt}, 1);
      v = m_buf[0];
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("stall_rvalid", {31'd0, rvalid}, 1);
      chk("stall_rdata", rdata, v);
      bus(1'b0, 10'h204, 4'hF, 0);
      chk("irq_disabled", {31'd0, irq}, 0);

      // core side ignored outside BUSY
      core_op(1'b1, 7'd6, ~m_buf[6], r);
      core_op(1'b0, 7'd6, 0, r);
      chk("core_rd_not_busy", r, 0);
      bus(1'b0, 10'h018, 4'hF, 0);

      // interrupt and W1C
      bus(1'b1, 10'h200, 4'hF, 32'h4);
      chk("irq_set", {31'd0, irq}, 1);
      chk("mode_write_done", {31'd0, core_mode}, 0);
      bus(1'b1, 10'h204, 4'hF, 32'h2);
      chk("irq_clr", {31'd0, irq}, 0);
      bus(1'b0, 10'h204, 4'hF, 0);

      // done and W1C in the same cycle: done wins
      bus(1'b1, 10'h200, 4'hF, 32'h5);
      chk("restart_pulse", {31'd0, core_start}, 1);
      @(negedge clk);
      core_done = 1'b1;
      req = 1'b1; we = 1'b1; addr = BASE + 32'h204; be = 4'h1; wdata = 32'h2;
      #1;
      chk("csr_gnt_busy", {31'd0, gnt}, 1);
      @(negedge clk);
      core_done = 1'b0; req = 1'b0;
      m_busy = 1'b0; m_done = 1'b1;
      #1;
      chk("w1c_race_rvalid", {31'd0, rvalid}, 1);
      chk("w1c_race_irq", {31'd0, irq}, 1);
      bus(1'b0, 10'h204, 4'hF, 0);
      bus(1'b1, 10'h204, 4'hF, 32'h2);

      // reset during BUSY with a response pending
      bus(1'b1, 10'h200, 4'hF, 32'h3);
      bus(1'b0, 10'h204, 4'hF, 0);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = BASE + 32'h204; be = 4'hF;
      @(posedge clk); #1;
      rst_n = 1'b0; req = 1'b0;
      #1;
      chk("mid_rst_rvalid", {31'd0, rvalid}, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_mode", {31'd0, core_mode}, 0);
      chk("mid_rst_start", {31'd0, core_start}, 0);
      chk("mid_rst_irq", {31'd0, irq}, 0);
      m_busy = 1'b0; m_done = 1'b0; m_mode = 1'b0; m_irqen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("no_start_after_rst", {31'd0, core_start}, 0);
      end
      bus(1'b0, 10'h204, 4'hF, 0);
      bus(1'b0, 10'h200, 4'hF, 0);
      bus(1'b0, 10'h004, 4'hF, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
